ram_loader: RTL and testbench



---
 rtl/ram_loader_pkg.sv | 20 ++
 rtl/ram_loader_ram_port_mux.sv | 24 ++
 rtl/ram_loader.sv | 139 +++++++++++++
 tb/tb_ram_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and frame geometry.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned FRAME_LEN      = 2 ** DEF_ADDR_WIDTH;

  // Number of data bytes in a frame for a given RAM address width.
  function automatic int unsigned frame_len(input int unsigned aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/ram_loader_ram_port_mux.sv
// RAM port selector: CPU bus while running, loader's registered bus while halted.
module ram_port_mux
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel_loader,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic [ADDR_WIDTH-1:0] ld_address,
  input  logic                  ld_we,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data
);

  assign ram_address = sel_loader ? ld_address : cpu_address;
  assign ram_we      = sel_loader ? ld_we      : cpu_we;
  assign ram_data    = sel_loader ? ld_data    : cpu_data;

endmodule

// File: rtl/ram_loader.sv
// Program loader: streams a framed image into the program RAM, reads it back
// to verify the frame checksum, then releases the CPU.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  cpu_halt,
  output logic                  done,
  output logic                  error
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on state, never on in_valid.

  localparam int unsigned LEN = frame_len(ADDR_WIDTH);
  localparam int VW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LEN - 1);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_we;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] chk;
  logic [DATA_WIDTH-1:0] sum_total;
  logic [VW-1:0]         vcnt;
  logic                  error_q;
  logic                  accept;
  logic                  verify_last;

  assign accept    = in_valid & in_ready;
  assign sum_total = sum + ram_rdata + chk;
  assign cpu_halt  = (state != ST_IDLE);
  assign error     = error_q;
  // The last VERIFY cycle sees the 16th read data on ram_rdata.
  assign verify_last = (state == ST_VERIFY) && (vcnt == VW'(LEN));
  assign done        = verify_last && (sum_total == '0);

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && addr_cnt == LAST_ADDR) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_VERIFY;
      end
      ST_VERIFY: if (verify_last) state_nx = (sum_total == '0) ? ST_IDLE : ST_ERROR;
      ST_ERROR:  if (start) state_nx = ST_LOAD;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_cnt <= '0;
      ld_addr  <= '0;
      ld_data  <= '0;
      ld_we    <= 1'b0;
      sum      <= '0;
      chk      <= '0;
      vcnt     <= '0;
      error_q  <= 1'b0;
    end else begin
      state <= state_nx;
      ld_we <= 1'b0;
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            addr_cnt <= '0;
            sum      <= '0;
            error_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            ld_addr  <= addr_cnt;
            ld_data  <= in_data;
            ld_we    <= 1'b1;
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_CHECK: begin
          if (accept) begin
            chk     <= in_data;
            ld_addr <= '0;
            vcnt    <= '0;
          end
        end
        ST_VERIFY: begin
          ld_addr <= ld_addr + ADDR_WIDTH'(1);
          vcnt    <= vcnt + VW'(1);
          // Read data trails the address by one cycle, so cycle 0 has nothing to add.
          if (vcnt != '0) sum <= sum + ram_rdata;
          if (verify_last && sum_total != '0) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  ram_port_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .sel_loader (cpu_halt),
    .cpu_address(cpu_address),
    .cpu_we     (cpu_we),
    .cpu_data   (cpu_data),
    .ld_address (ld_addr),
    .ld_we      (ld_we),
    .ld_data    (ld_data),
    .ram_address(ram_address),
    .ram_we     (ram_we),
    .ram_data   (ram_data)
  );

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: random framed loads against a frame-level reference
// model, with a write/result scoreboard fed by the driver and drained by a monitor.
module tb_ram_loader;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LEN = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] cpu_address;
  logic          cpu_we;
  logic [DW-1:0] cpu_data;
  logic [AW-1:0] ram_address;
  logic          ram_we;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_rdata;
  logic          cpu_halt;
  logic          done;
  logic          error;

  ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_address(cpu_address), .cpu_we(cpu_we), .cpu_data(cpu_data),
    .ram_address(ram_address), .ram_we(ram_we), .ram_data(ram_data),
    .ram_rdata(ram_rdata), .cpu_halt(cpu_halt), .done(done), .error(error)
  );

  // ---------------- clock / reset / RAM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [LEN];
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_data;
    ram_rdata <= mem[ram_address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];   // expected loader writes {address, data}
  logic             exp_res[$]; // expected frame outcome: 1 = done, 0 = error
  int               n_vec = 0;
  int               n_err = 0;
  logic             err_d = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_halt && ram_we) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_write: got addr %0h data %0h expected none", ram_address, ram_data);
        end else begin
          check("write", {ram_address, ram_data}, exp_q.pop_front());
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done=1 expected no outcome");
        end else check("result_done", 1, exp_res.pop_front());
      end
      if (error && !err_d) begin
        if (exp_res.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_error: got error=1 expected no outcome");
        end else check("result_error", 0, exp_res.pop_front());
      end
    end
    err_d = error;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] frame [LEN+1];
  logic [DW-1:0] img   [LEN];

  function automatic int unsigned frame_sum();
    int unsigned s = 0;
    for (int i = 0; i < LEN; i++) s += frame[i];
    return s;
  endfunction

  function automatic logic [DW-1:0] good_chk();
    return DW'((256 - (frame_sum() % 256)) % 256);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [DW-1:0] b, input int gap);
    bit ok = 0;
    repeat (gap) begin in_valid = 1'b0; @(negedge clk); end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (in_ready) ok = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("halt_rise", cpu_halt, 1);
  endtask

  task automatic run_frame(input int max_gap, input bit hold_verify);
    bit pass;
    pass = ((frame_sum() + frame[LEN]) % 256) == 0;
    pulse_start();
    for (int i = 0; i < LEN; i++) begin
      exp_q.push_back({AW'(i), frame[i]});
      img[i] = frame[i];
      send_byte(frame[i], (max_gap < 0) ? (i % 2) : $urandom_range(0, max_gap));
    end
    exp_res.push_back(pass);
    send_byte(frame[LEN], (max_gap < 0) ? 1 : $urandom_range(0, max_gap));
    // Readback: addresses 0..15 on consecutive cycles, no writes, nothing accepted.
    for (int k = 0; k < LEN; k++) begin
      in_valid = hold_verify;
      in_data  = 8'hEE;
      check("verify_addr", ram_address, k);
      check("verify_we", ram_we, 0);
      check("verify_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = hold_verify;
    for (int t = 0; t < 50 && exp_res.size() != 0; t++) @(negedge clk);
    in_valid = 1'b0;
    if (exp_res.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL outcome_timeout: got no done/error expected outcome %0d", pass);
      exp_res.delete();
    end
    @(negedge clk);
    check("halt_after", cpu_halt, pass ? 0 : 1);
    check("error_after", error, pass ? 0 : 1);
    check("writes_pending", exp_q.size(), 0);
    for (int i = 0; i < LEN; i++) check("ram_image", mem[i], img[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < LEN; i++) begin mem[i] = '0; img[i] = '0; end
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    cpu_address = '0; cpu_we = 1'b0; cpu_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_cpu_halt", cpu_halt, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_halt", cpu_halt, 0);
    check("idle_ready", in_ready, 0);
    in_valid = 1'b0;

    // Pass-through in IDLE, zero latency.
    cpu_address = 4'd3; cpu_we = 1'b1; cpu_data = 8'h5A;
    #1;
    check("pt_address", ram_address, 3);
    check("pt_we", ram_we, 1);
    check("pt_data", ram_data, 8'h5A);
    for (int n = 0; n < 4; n++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          w;
      a = AW'($urandom_range(0, LEN - 1));
      d = DW'($urandom_range(0, 255));
      w = 1'($urandom_range(0, 1));
      cpu_address = a; cpu_data = d; cpu_we = w;
      #1;
      check("pt_rand", {ram_address, ram_we, ram_data}, {a, w, d});
    end
    cpu_we = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Good load 0x01..0x10 with checksum 0x78, back-to-back.
    for (int i = 0; i < LEN; i++) frame[i] = DW'(i + 1);
    frame[LEN] = 8'h78;
    run_frame(0, 1'b0);

    // Bad checksum, then recover from ERROR with a good frame.
    frame[LEN] = 8'h00;
    run_frame(0, 1'b0);
    repeat (3) @(negedge clk);
    check("err_halt_hold", cpu_halt, 1);
    check("err_sticky", error, 1);
    for (int i = 0; i < LEN; i++) frame[i] = DW'($urandom_range(0, 255));
    frame[LEN] = good_chk();
    run_frame(0, 1'b0);

    // Throttled stream with in_valid held during readback.
    for (int i = 0; i < LEN; i++) frame[i] = DW'($urandom_range(0, 255));
    frame[LEN] = good_chk();
    run_frame(-1, 1'b1);

    // Reset after the 7th byte: its write is dropped.
    for (int i = 0; i < LEN; i++) frame[i] = img[i] ^ 8'h5A;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({AW'(i), frame[i]});
      if (i < 6) img[i] = frame[i];
      send_byte(frame[i], 0);
    end
    #1 rst_n = 1'b0;
    #1;
    check("midrst_halt", cpu_halt, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_we", ram_we, 0);
    check("midrst_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LEN; i++) check("midrst_image", mem[i], img[i]);
    for (int i = 0; i < LEN; i++) frame[i] = DW'($urandom_range(0, 255));
    frame[LEN] = good_chk();
    run_frame(1, 1'b0);

    // Random frames, mixed good/bad checksums and random throttling.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < LEN; i++) frame[i] = DW'($urandom_range(0, 255));
      frame[LEN] = ($urandom_range(0, 1) == 1) ? good_chk() : DW'($urandom_range(0, 255));
      run_frame(2, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
